axis_dot_seq: RTL and testbench

- Dot-product sequencer that sits directly upstream of axis_fmac and consumes its results.
- Accepts a stream of (a,b) float32 element pairs, terminated by TLAST, and issues A=a, B=b, C=partial-sum to the fmac.
- Rotates over LATENCY+1 partial-sum lanes so the fmac pipeline can run at full throughput with no read-after-write stall.
- At vector end, folds the lanes through the same fmac (B=1.0) and emits one float32 dot product on an AXI-Stream master.

---
 rtl/axis_dot_seq_pkg.sv | 23 ++
 rtl/axis_dot_seq_tag_delay_line.sv | 40 ++++
 rtl/axis_dot_seq.sv | 157 +++++++++++++++
 tb/tb_axis_dot_seq.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_dot_seq_pkg.sv
// Shared types for the dot-product sequencer: FSM states, float constants
// and the {valid, lane} tag that tracks each fmac operation in flight.
package dot_pkg;

    localparam int LANE_W = 4;

    localparam logic [31:0] FP_ONE  = 32'h3F80_0000;
    localparam logic [31:0] FP_ZERO = 32'h0000_0000;

    typedef enum logic [2:0] {
        ACCUM,
        DRAIN,
        REDUCE_ISSUE,
        REDUCE_WAIT,
        OUT
    } state_e;

    typedef struct packed {
        logic              valid;
        logic [LANE_W-1:0] lane;
    } tag_t;

endpackage

// File: rtl/axis_dot_seq_tag_delay_line.sv
// Shift register that follows each fmac issue through the pipeline so the
// result can be steered back to the lane it belongs to.
module tag_delay_line
    import dot_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  tag_t tag_i,
    output tag_t head_o,
    output logic busy_o
);

    tag_t stage_q [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= tag_i;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign head_o = stage_q[DEPTH-1];

    // Busy ignores the head: a head tag retires in the current cycle.
    always_comb begin
        busy_o = 1'b0;
        for (int i = 0; i < DEPTH - 1; i++) begin
            busy_o = busy_o | stage_q[i].valid;
        end
    end

endmodule

// File: rtl/axis_dot_seq.sv
// Dot-product sequencer in front of axis_fmac: spreads products over
// LATENCY+1 partial-sum lanes, then folds the lanes into one result.
module axis_dot_seq
    import dot_pkg::*;
#(
    parameter int LATENCY = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] S_A_TDATA,
    input  logic [31:0] S_B_TDATA,
    input  logic        S_TVALID,
    input  logic        S_TLAST,
    output logic        S_TREADY,
    output logic [31:0] F_A_TDATA,
    output logic [31:0] F_B_TDATA,
    output logic [31:0] F_C_TDATA,
    output logic        F_TVALID,
    input  logic [31:0] F_OUT_TDATA,
    input  logic        F_OUT_TVALID,
    output logic [31:0] M_TDATA,
    output logic        M_TVALID,
    input  logic        M_TREADY
);

    localparam int NLANES = LATENCY + 1;
    localparam int IDX_W  = $clog2(NLANES);
    localparam logic [IDX_W-1:0] LAST_LANE = IDX_W'(NLANES - 1);

    state_e            state_q, state_d;
    logic [31:0]       lane_q [NLANES];
    logic [NLANES-1:0] used_q, used_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [IDX_W-1:0]  red_q, red_d;
    logic [IDX_W-1:0]  red_nxt;

    tag_t tag_in;
    tag_t tag_head;
    logic tag_busy;
    logic wr_en;

    tag_delay_line #(
        .DEPTH (LATENCY)
    ) u_tags (
        .clk    (clk),
        .rst    (rst),
        .tag_i  (tag_in),
        .head_o (tag_head),
        .busy_o (tag_busy)
    );

    assign wr_en   = tag_head.valid & F_OUT_TVALID;
    assign red_nxt = red_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        used_d    = used_q;
        ptr_d     = ptr_q;
        red_d     = red_q;
        tag_in    = '0;
        S_TREADY  = 1'b0;
        F_TVALID  = 1'b0;
        F_A_TDATA = FP_ZERO;
        F_B_TDATA = FP_ZERO;
        F_C_TDATA = FP_ZERO;
        M_TVALID  = 1'b0;
        M_TDATA   = FP_ZERO;

        case (state_q)
            ACCUM: begin
                S_TREADY = !rst;
                if (S_TVALID && !rst) begin
                    F_TVALID    = 1'b1;
                    F_A_TDATA   = S_A_TDATA;
                    F_B_TDATA   = S_B_TDATA;
                    F_C_TDATA   = used_q[ptr_q] ? lane_q[ptr_q] : FP_ZERO;
                    tag_in.valid = 1'b1;
                    tag_in.lane  = LANE_W'(ptr_q);
                    used_d[ptr_q] = 1'b1;
                    ptr_d = (ptr_q == LAST_LANE) ? '0 : ptr_q + 1'b1;
                    if (S_TLAST) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // Lanes fill from 0 upward, so lane 1 unused means one lane.
                if (!tag_busy) begin
                    if (used_q[1]) begin
                        red_d   = IDX_W'(1);
                        state_d = REDUCE_ISSUE;
                    end else begin
                        state_d = OUT;
                    end
                end
            end
            REDUCE_ISSUE: begin
                F_TVALID  = 1'b1;
                F_A_TDATA = lane_q[red_q];
                F_B_TDATA = FP_ONE;
                F_C_TDATA = lane_q[0];
                tag_in.valid = 1'b1;
                tag_in.lane  = '0;
                state_d = REDUCE_WAIT;
            end
            REDUCE_WAIT: begin
                if (wr_en && tag_head.lane == '0) begin
                    if (red_q != LAST_LANE && used_q[red_nxt]) begin
                        red_d   = red_nxt;
                        state_d = REDUCE_ISSUE;
                    end else begin
                        state_d = OUT;
                    end
                end
            end
            OUT: begin
                M_TVALID = 1'b1;
                M_TDATA  = lane_q[0];
                if (M_TREADY) begin
                    used_d  = '0;
                    ptr_d   = '0;
                    state_d = ACCUM;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ACCUM;
            used_q  <= '0;
            ptr_q   <= '0;
            red_q   <= '0;
        end else begin
            state_q <= state_d;
            used_q  <= used_d;
            ptr_q   <= ptr_d;
            red_q   <= red_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NLANES; i++) begin
                lane_q[i] <= FP_ZERO;
            end
        end else if (wr_en) begin
            for (int i = 0; i < NLANES; i++) begin
                if (tag_head.lane == LANE_W'(i)) begin
                    lane_q[i] <= F_OUT_TDATA;
                end
            end
        end
    end

endmodule

// File: tb/tb_axis_dot_seq.sv
// Bench for axis_dot_seq with a behavioural fmac attached; vector results
// are compared with a plain-arithmetic dot-product model.
module tb_axis_dot_seq;

    localparam int LATENCY = 4;
    localparam int NLANES  = LATENCY + 1;
    localparam logic [31:0] ONE_F = 32'h3F80_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] S_A_TDATA, S_B_TDATA;
    logic        S_TVALID, S_TLAST, S_TREADY;
    logic [31:0] F_A_TDATA, F_B_TDATA, F_C_TDATA;
    logic        F_TVALID;
    logic [31:0] F_OUT_TDATA;
    logic        F_OUT_TVALID;
    logic [31:0] M_TDATA;
    logic        M_TVALID, M_TREADY;

    always #5 clk = ~clk;

    axis_dot_seq #(.LATENCY(LATENCY)) dut (
        .clk          (clk),
        .rst          (rst),
        .S_A_TDATA    (S_A_TDATA),
        .S_B_TDATA    (S_B_TDATA),
        .S_TVALID     (S_TVALID),
        .S_TLAST      (S_TLAST),
        .S_TREADY     (S_TREADY),
        .F_A_TDATA    (F_A_TDATA),
        .F_B_TDATA    (F_B_TDATA),
        .F_C_TDATA    (F_C_TDATA),
        .F_TVALID     (F_TVALID),
        .F_OUT_TDATA  (F_OUT_TDATA),
        .F_OUT_TVALID (F_OUT_TVALID),
        .M_TDATA      (M_TDATA),
        .M_TVALID     (M_TVALID),
        .M_TREADY     (M_TREADY)
    );

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        int e;
        if (r == 0.0) return 32'h0;
        d = $realtobits(r);
        e = int'(d[62:52]) - 1023 + 127;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    function automatic real f2r(input logic [31:0] f);
        logic [63:0] d;
        int e;
        if (f[30:0] == 31'h0) return 0.0;
        e = int'(f[30:23]) - 127 + 1023;
        d = {f[31], e[10:0], f[22:0], 29'h0};
        return $bitstoreal(d);
    endfunction

    // Fmac model: fixed LATENCY pipeline computing a*b+c; it has no reset,
    // so results issued before a DUT reset still come out afterwards.
    logic        fm_v [LATENCY];
    logic [31:0] fm_d [LATENCY];

    initial begin
        for (int i = 0; i < LATENCY; i++) begin
            fm_v[i] = 1'b0;
            fm_d[i] = 32'h0;
        end
    end

    always @(posedge clk) begin
        fm_v[0] <= F_TVALID;
        fm_d[0] <= r2f(f2r(F_A_TDATA) * f2r(F_B_TDATA) + f2r(F_C_TDATA));
        for (int i = 1; i < LATENCY; i++) begin
            fm_v[i] <= fm_v[i-1];
            fm_d[i] <= fm_d[i-1];
        end
    end

    assign F_OUT_TVALID = fm_v[LATENCY-1];
    assign F_OUT_TDATA  = fm_d[LATENCY-1];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          iss_tot = 0, fold_tot = 0, foldbad_tot = 0, stall_tot = 0;
    int          acc_cyc = 0;
    logic [31:0] acc_c_last = 32'h0;

    always @(negedge clk) begin
        if (!rst) begin
            if (F_TVALID) begin
                iss_tot++;
                if (S_TREADY) begin
                    acc_c_last = F_C_TDATA;
                end else begin
                    fold_tot++;
                    if (F_B_TDATA !== ONE_F) foldbad_tot++;
                end
            end
            if (S_TVALID && !S_TREADY) stall_tot++;
            if (S_TVALID && S_TREADY) acc_cyc = cyc;
        end
    end

    int total = 0, passed = 0, fails = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    real         va[$], vb[$];
    logic [31:0] last_m;
    int          last_lat;

    task automatic drive_elems(input int gap_mode);
        int  n;
        int  g;
        bit  ok;
        n = va.size();
        for (int k = 0; k < n; k++) begin
            S_A_TDATA = r2f(va[k]);
            S_B_TDATA = r2f(vb[k]);
            S_TLAST   = (k == n - 1);
            S_TVALID  = 1'b1;
            ok = 1'b0;
            for (int w = 0; w < 50 && !ok; w++) begin
                #2;
                ok = S_TREADY;
                tick();
            end
            if (!ok) check("accept_timeout", 32'd0, 32'd1);
            S_TVALID = 1'b0;
            S_TLAST  = 1'b0;
            g = (gap_mode < 0) ? int'($urandom_range(0, 2)) : gap_mode;
            repeat (g) tick();
        end
    endtask

    task automatic run_vec(input int gap_mode, input int hold);
        int          n, used, i0, f0, fb0, s0, t_last, rise, exp_rise;
        real         lanes [NLANES];
        real         sum;
        logic [31:0] exp;
        bit          seen;
        n    = va.size();
        used = (n < NLANES) ? n : NLANES;
        for (int j = 0; j < NLANES; j++) lanes[j] = 0.0;
        for (int k = 0; k < n; k++) lanes[k % NLANES] = lanes[k % NLANES] + va[k] * vb[k];
        sum = lanes[0];
        for (int j = 1; j < used; j++) sum = sum + lanes[j];
        exp = r2f(sum);

        i0 = iss_tot; f0 = fold_tot; fb0 = foldbad_tot; s0 = stall_tot;
        drive_elems(gap_mode);
        t_last = acc_cyc;

        seen = 1'b0;
        for (int w = 0; w < 400 && !seen; w++) begin
            @(negedge clk);
            seen = M_TVALID;
        end
        if (!seen) begin
            check("m_tvalid_timeout", 32'd0, 32'd1);
            return;
        end
        rise     = cyc;
        exp_rise = t_last + LATENCY + (used - 1) * (LATENCY + 1) + 1;
        last_lat = rise - t_last;
        last_m   = M_TDATA;
        check("latency", rise, exp_rise);
        check("result", M_TDATA, exp);
        check("fold_issues", fold_tot - f0, used - 1);
        check("fold_b_one", foldbad_tot - fb0, 0);
        check("accum_issues", (iss_tot - i0) - (fold_tot - f0), n);
        check("no_stall", stall_tot - s0, 0);

        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("hold_data", M_TDATA, exp);
            check("hold_valid_ready", {30'h0, M_TVALID, S_TREADY}, 32'h2);
        end
        @(posedge clk);
        #1 M_TREADY = 1'b1;
        @(posedge clk);
        #1 M_TREADY = 1'b0;
        #1 check("after_handshake", {30'h0, M_TVALID, S_TREADY}, 32'h1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, f0;
        bit seen;
        rst = 1'b1;
        S_A_TDATA = '0; S_B_TDATA = '0; S_TVALID = 1'b0; S_TLAST = 1'b0;
        M_TREADY = 1'b0;
        repeat (3) tick();
        check("reset_ctrl", {29'h0, S_TREADY, F_TVALID, M_TVALID}, 32'h0);
        check("reset_mdata", M_TDATA, 32'h0);
        check("reset_fdata", F_A_TDATA | F_B_TDATA | F_C_TDATA, 32'h0);
        rst = 1'b0;
        tick();
        check("ready_after_reset", {31'h0, S_TREADY}, 32'h1);

        // Single element: 2.0 * 3.0.
        va = '{2.0}; vb = '{3.0};
        run_vec(0, 0);
        check("n1_value", last_m, 32'h40C0_0000);
        check("n1_latency", last_lat, LATENCY + 1);
        check("n1_c_zero", acc_c_last, 32'h0);

        // Four back-to-back elements folded three times.
        va = '{1.0, 2.0, 3.0, 4.0}; vb = '{1.0, 1.0, 1.0, 1.0};
        run_vec(0, 0);
        check("n4_value", last_m, 32'h4120_0000);
        check("n4_latency", last_lat, 20);

        // Twelve elements wrap the lane pointer twice.
        va.delete(); vb.delete();
        for (int k = 0; k < 12; k++) begin va.push_back(1.0); vb.push_back(0.5); end
        run_vec(0, 0);
        check("n12_value", last_m, 32'h40C0_0000);

        // Single element again, with stale lane contents from the last vector.
        va = '{1.5}; vb = '{4.0};
        run_vec(0, 0);
        check("n1_stale_value", last_m, 32'h40C0_0000);
        check("n1_stale_c_zero", acc_c_last, 32'h0);

        // Gapped input with a stalled downstream.
        va = '{1.0, 2.0, 3.0}; vb = '{2.0, 2.0, 2.0};
        run_vec(2, 6);
        check("gap_value", last_m, 32'h4140_0000);

        // Reset while waiting on a fold result.
        va = '{1.0, 2.0, 3.0, 4.0, 5.0}; vb = '{1.0, 1.0, 1.0, 1.0, 1.0};
        f0 = fold_tot;
        drive_elems(0);
        seen = 1'b0;
        for (int w = 0; w < 100 && !seen; w++) begin
            @(negedge clk);
            seen = (fold_tot > f0);
        end
        check("fold_started", {31'h0, seen}, 32'h1);
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("midrst_ctrl", {29'h0, S_TREADY, F_TVALID, M_TVALID}, 32'h0);
        check("midrst_data", M_TDATA | F_A_TDATA | F_B_TDATA | F_C_TDATA, 32'h0);
        tick();
        rst = 1'b0;
        va = '{2.0}; vb = '{3.0};
        run_vec(0, 0);
        check("post_reset_value", last_m, 32'h40C0_0000);

        // Randomised vectors with random gaps and downstream backpressure.
        for (int r = 0; r < 8; r++) begin
            n = int'($urandom_range(1, 14));
            va.delete(); vb.delete();
            for (int k = 0; k < n; k++) begin
                va.push_back(real'($urandom_range(0, 7)));
                vb.push_back(real'($urandom_range(0, 7)));
            end
            run_vec(-1, int'($urandom_range(0, 3)));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
